// File: rtl/instruction_fetch.sv
// LC2K instruction fetch stage.
// Holds the program counter and fetches one instruction word at a time
// from instruction memory over a valid/ready request channel and a
// valid-only response channel. Each fetched word is held for decode
// together with its PC. The stage then waits for the PC mux to supply
// the next PC. Fetch stops for good on the halt opcode, and only reset
// leaves that condition.
module instruction_fetch #(
  parameter int unsigned           ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [2:0]            HALT_OPCODE = 3'b110
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [31:0]           imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst_data,
  output logic [31:0]           inst_pc,
  input  logic                  next_pc_valid,
  input  logic [31:0]           next_pc,
  output logic                  halted,
  output logic [31:0]           fetch_count
);

  // One state per phase of a fetch. HALTED is terminal.
  typedef enum logic [2:0] {
    REQ       = 3'd0,
    WAIT_RESP = 3'd1,
    HOLD      = 3'd2,
    WAIT_PC   = 3'd3,
    HALTED    = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [31:0]           inst_q;
  logic [31:0]           inst_next;
  logic [31:0]           count_q;
  logic [31:0]           count_next;
  logic                  is_halt;

  // The opcode field sits in bits 24:22 of an LC2K instruction word.
  assign is_halt = (inst_q[24:22] == HALT_OPCODE);

  // Registers all state. Reset is synchronous and overrides every handshake.
  // A handshake that arrives in the reset cycle is therefore lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= REQ;
      pc      <= RESET_PC;
      inst_q  <= '0;
      count_q <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      inst_q  <= inst_next;
      count_q <= count_next;
    end
  end

  // Next-state and datapath update. Each state reacts only to its own
  // handshake, so stray responses, early next-PC strobes and inst_ready
  // outside HOLD fall through to the hold-everything defaults. A
  // next_pc_valid in the HOLD->WAIT_PC cycle is dropped on purpose: the
  // PC mux result only counts once the stage is actually in WAIT_PC.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    inst_next  = inst_q;
    count_next = count_q;
    unique case (state)
      REQ: begin
        if (imem_req_ready) begin
          state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (imem_resp_valid) begin
          inst_next  = imem_resp_data;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          count_next = count_q + 32'd1;
          state_next = is_halt ? HALTED : WAIT_PC;
        end
      end
      WAIT_PC: begin
        if (next_pc_valid) begin
          pc_next    = next_pc[ADDR_WIDTH-1:0];
          state_next = REQ;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = REQ;
      end
    endcase
  end

  // All outputs are decoded from state or taken straight from registers,
  // so decode and memory never see a combinational input-to-output path.
  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == HOLD);
  assign inst_data      = inst_q;
  assign inst_pc        = 32'(pc);
  assign halted         = (state == HALTED);
  assign fetch_count    = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed table-driven bench for instruction_fetch.
// Each record holds the inputs for one clock edge and the outputs that
// must be visible just after that edge.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        next_pc_valid;
  logic [31:0] next_pc;
  logic        halted;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        inst_ready;
    logic        npc_valid;
    logic [31:0] npc;
    logic        e_req_valid;
    logic [15:0] e_addr;
    logic        e_inst_valid;
    logic [31:0] e_data;
    logic        e_halted;
    logic [31:0] e_count;
  } vec_t;

  instruction_fetch #(
    .ADDR_WIDTH (16),
    .RESET_PC   (16'h0000),
    .HALT_OPCODE(3'b110)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .next_pc_valid  (next_pc_valid),
    .next_pc        (next_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rst, input logic rdy, input logic rv, input logic [31:0] rd,
    input logic ir, input logic nv, input logic [31:0] np,
    input logic erv, input logic [15:0] ea, input logic eiv,
    input logic [31:0] ed, input logic eh, input logic [31:0] ec);
    vec_t v;
    v.rst = rst; v.req_ready = rdy; v.resp_valid = rv; v.resp_data = rd;
    v.inst_ready = ir; v.npc_valid = nv; v.npc = np;
    v.e_req_valid = erv; v.e_addr = ea; v.e_inst_valid = eiv;
    v.e_data = ed; v.e_halted = eh; v.e_count = ec;
    return v;
  endfunction

  // Drives one record's inputs on the falling edge and waits until just
  // after the following rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset           = v.rst;
    imem_req_ready  = v.req_ready;
    imem_resp_valid = v.resp_valid;
    imem_resp_data  = v.resp_data;
    inst_ready      = v.inst_ready;
    next_pc_valid   = v.npc_valid;
    next_pc         = v.npc;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got 0x%08h expected 0x%08h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    cmp(name, "imem_req_valid", 32'(imem_req_valid), 32'(v.e_req_valid));
    cmp(name, "imem_req_addr",  32'(imem_req_addr),  32'(v.e_addr));
    cmp(name, "inst_valid",     32'(inst_valid),     32'(v.e_inst_valid));
    cmp(name, "inst_data",      inst_data,           v.e_data);
    cmp(name, "inst_pc",        inst_pc,             {16'h0000, v.e_addr});
    cmp(name, "halted",         32'(halted),         32'(v.e_halted));
    cmp(name, "fetch_count",    fetch_count,         v.e_count);
  endtask

  task automatic step(input string name, input vec_t v);
    applyStimulus(v);
    checkOutput(name, v);
  endtask

  vec_t vecs[21];

  initial begin
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = '0; inst_ready = 1'b0; next_pc_valid = 1'b0; next_pc = '0;

    //                rst rdy rv data          ir nv npc           erv addr   eiv data          h cnt
    vecs[0]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,          1, 16'h0,  0, 32'h0,         0, 0);
    vecs[1]  = mk(0, 1, 1, 32'h0000_0BAD, 0, 0, 32'h0,          0, 16'h0,  0, 32'h0,         0, 0);
    vecs[2]  = mk(0, 0, 1, 32'h0000_1111, 0, 0, 32'h0,          0, 16'h0,  1, 32'h0000_1111, 0, 0);
    vecs[3]  = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 16'h0,  0, 32'h0000_1111, 0, 1);
    vecs[4]  = mk(0, 0, 0, 32'h0,         0, 1, 32'h1,          1, 16'h1,  0, 32'h0000_1111, 0, 1);
    vecs[5]  = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 16'h1,  0, 32'h0000_1111, 0, 1);
    vecs[6]  = mk(0, 0, 1, 32'h0000_2222, 0, 0, 32'h0,          0, 16'h1,  1, 32'h0000_2222, 0, 1);
    vecs[7]  = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 16'h1,  0, 32'h0000_2222, 0, 2);
    vecs[8]  = mk(0, 0, 0, 32'h0,         0, 1, 32'h2,          1, 16'h2,  0, 32'h0000_2222, 0, 2);
    vecs[9]  = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 16'h2,  0, 32'h0000_2222, 0, 2);
    vecs[10] = mk(0, 0, 1, 32'h0000_3333, 0, 0, 32'h0,          0, 16'h2,  1, 32'h0000_3333, 0, 2);
    vecs[11] = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 16'h2,  0, 32'h0000_3333, 0, 3);
    vecs[12] = mk(0, 0, 0, 32'h0,         0, 1, 32'h3,          1, 16'h3,  0, 32'h0000_3333, 0, 3);
    vecs[13] = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 16'h3,  0, 32'h0000_3333, 0, 3);
    vecs[14] = mk(0, 0, 1, 32'h0000_4444, 0, 0, 32'h0,          0, 16'h3,  1, 32'h0000_4444, 0, 3);
    vecs[15] = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,          0, 16'h3,  0, 32'h0000_4444, 0, 4);
    vecs[16] = mk(0, 0, 1, 32'hDEAD_BEEF, 1, 1, 32'h10,         1, 16'h10, 0, 32'h0000_4444, 0, 4);
    vecs[17] = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 16'h10, 0, 32'h0000_4444, 0, 4);
    vecs[18] = mk(0, 0, 1, 32'h0000_5555, 0, 0, 32'h0,          0, 16'h10, 1, 32'h0000_5555, 0, 4);
    vecs[19] = mk(0, 0, 0, 32'h0,         1, 1, 32'h77,         0, 16'h10, 0, 32'h0000_5555, 0, 5);
    vecs[20] = mk(0, 0, 0, 32'h0,         0, 1, 32'h0001_0005,  1, 16'h5,  0, 32'h0000_5555, 0, 5);

    for (int i = 0; i < 21; i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Request backpressure: address must stay put while memory stalls.
    for (int i = 0; i < 4; i++)
      step("req_stall", mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 1, 16'h5, 0, 32'h0000_5555, 0, 5));
    step("req_accept", mk(0, 1, 0, 32'h0, 0, 0, 32'h0, 0, 16'h5, 0, 32'h0000_5555, 0, 5));
    step("resp_abcd",  mk(0, 0, 1, 32'h0000_ABCD, 0, 0, 32'h0, 0, 16'h5, 1, 32'h0000_ABCD, 0, 5));
    // Decode backpressure: instruction and PC held, count unchanged.
    for (int i = 0; i < 3; i++)
      step("dec_stall", mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 16'h5, 1, 32'h0000_ABCD, 0, 5));
    step("dec_take",   mk(0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 16'h5, 0, 32'h0000_ABCD, 0, 6));

    // Halt instruction: opcode field 110 stops fetch permanently.
    step("npc6",       mk(0, 0, 0, 32'h0, 0, 1, 32'h6, 1, 16'h6, 0, 32'h0000_ABCD, 0, 6));
    step("req6",       mk(0, 1, 0, 32'h0, 0, 0, 32'h0, 0, 16'h6, 0, 32'h0000_ABCD, 0, 6));
    step("resp_halt",  mk(0, 0, 1, 32'h0180_0000, 0, 0, 32'h0, 0, 16'h6, 1, 32'h0180_0000, 0, 6));
    step("take_halt",  mk(0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 16'h6, 0, 32'h0180_0000, 1, 7));
    for (int i = 0; i < 20; i++)
      step("halted_idle", mk(0, 1, 1, 32'h1234_5678, 1, 1, 32'(i + 40),
                             0, 16'h6, 0, 32'h0180_0000, 1, 7));

    // Reset mid-fetch, then a stale response while back in REQ.
    step("rst",        mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 16'h0, 0, 32'h0, 0, 0));
    step("req0",       mk(0, 1, 0, 32'h0, 0, 0, 32'h0, 0, 16'h0, 0, 32'h0, 0, 0));
    step("rst_resp",   mk(1, 0, 1, 32'h0000_BEEF, 0, 0, 32'h0, 1, 16'h0, 0, 32'h0, 0, 0));
    step("stale_resp", mk(0, 0, 1, 32'h0000_CAFE, 0, 0, 32'h0, 1, 16'h0, 0, 32'h0, 0, 0));
    step("rereq",      mk(0, 1, 0, 32'h0, 0, 0, 32'h0, 0, 16'h0, 0, 32'h0, 0, 0));
    step("resp_1234",  mk(0, 0, 1, 32'h0000_1234, 0, 0, 32'h0, 0, 16'h0, 1, 32'h0000_1234, 0, 0));
    step("take_1234",  mk(0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 16'h0, 0, 32'h0000_1234, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
